// File: rtl/operand_stack_if.sv
// Request/response bundle between the core and its operand stack.
// The stack owns the slave side; the core drives the master side.
interface operand_stack_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             push_w32;
    logic [WIDTH-1:0] push_data;
    logic [1:0]       pop;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] next;
    logic             result_empty;
    logic             full;
    logic [CW-1:0]    count;
    logic [3:0]       trap;

    modport master (
        output push, push_w32, push_data, pop,
        input  result, next, result_empty, full, count, trap
    );

    modport slave (
        input  push, push_w32, push_data, pop,
        output result, next, result_empty, full, count, trap
    );
endinterface

// File: rtl/operand_stack.sv
// Operand stack: pop 0-2 and push 0-1 entries per cycle, sticky trap.
// Top and next-below-top are exposed combinationally from registered state.
module operand_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input logic             clk,
    input logic             reset,
    operand_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [3:0]       trap_q;
    logic [3:0]       err;
    logic [CW:0]      sum;
    logic             ok;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nxt_idx;
    logic [WIDTH-1:0] wr_data;

    always_comb begin
        sum = {1'b0, sp} - (CW+1)'(bus.pop) + (CW+1)'(bus.push);
        err = 4'd0;
        // Error priority: illegal pop, then underflow, then overflow
        if (bus.pop == 2'd3)
            err = 4'd3;
        else if ((CW+1)'(bus.pop) > {1'b0, sp})
            err = 4'd1;
        else if (sum > (CW+1)'(DEPTH))
            err = 4'd2;
        ok      = (trap_q == 4'd0) && (err == 4'd0);
        wr_idx  = AW'(sp - CW'(bus.pop));
        top_idx = AW'(sp - CW'(1));
        nxt_idx = AW'(sp - CW'(2));
        wr_data = bus.push_w32 ? WIDTH'(bus.push_data[31:0])
                               : bus.push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp     <= '0;
            trap_q <= 4'd0;
        end else if (trap_q == 4'd0) begin
            if (err != 4'd0)
                trap_q <= err;
            else
                sp <= sum[CW-1:0];
        end
    end

    // Popped slots keep stale data; the outputs mask them by sp
    always_ff @(posedge clk) begin
        if (reset && ok && bus.push)
            mem[wr_idx] <= wr_data;
    end

    assign bus.result       = (sp != '0) ? mem[top_idx] : '0;
    assign bus.next         = (sp >= CW'(2)) ? mem[nxt_idx] : '0;
    assign bus.result_empty = (sp == '0);
    assign bus.full         = (sp == CW'(DEPTH));
    assign bus.count        = sp;
    assign bus.trap         = trap_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed vector bench for operand_stack at WIDTH=64, DEPTH=4.
// One table row per clock, plus a hand-written full-stack rotate.
module tb_operand_stack;
    localparam int W = 64;
    localparam int D = 4;

    typedef struct {
        logic         rst;
        logic         push;
        logic         w32;
        logic [W-1:0] data;
        logic [1:0]   pop;
        logic [2:0]   cnt;
        logic [W-1:0] res;
        logic [W-1:0] nxt;
        logic         emp;
        logic         ful;
        logic [3:0]   trp;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vq[$];

    operand_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

    operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic push, input logic w32,
        input logic [W-1:0] data, input logic [1:0] pop,
        input logic [2:0] cnt, input logic [W-1:0] res,
        input logic [W-1:0] nxt, input logic emp,
        input logic ful, input logic [3:0] trp
    );
        vec_t v;
        v.rst = rst; v.push = push; v.w32 = w32;
        v.data = data; v.pop = pop; v.cnt = cnt;
        v.res = res; v.nxt = nxt; v.emp = emp;
        v.ful = ful; v.trp = trp;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic push,
                         input logic w32, input logic [W-1:0] data,
                         input logic [1:0] pop);
        @(negedge clk);
        reset         = rst;
        bus.push      = push;
        bus.push_w32  = w32;
        bus.push_data = data;
        bus.pop       = pop;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.push = 1'b0;
        bus.push_w32 = 1'b0;
        bus.push_data = '0;
        bus.pop = 2'd0;

        // reset, then idle
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1,0,0,0,0, 0,0,0,1,0,0));
        // push 1, push 2, atomic pop2/push1 of the compare result
        vq.push_back(mk(1,1,0,64'h1,0, 1,64'h1,0,0,0,0));
        vq.push_back(mk(1,1,0,64'h2,0, 2,64'h2,64'h1,0,0,0));
        vq.push_back(mk(1,1,0,64'h0,2, 1,0,0,0,0,0));
        // 32-bit push zero-extends
        vq.push_back(mk(1,1,1,64'hFFFF_FFFF_8000_0001,0,
                        2,64'h0000_0000_8000_0001,0,0,0,0));
        // a push presented during reset is discarded
        vq.push_back(mk(0,1,0,64'h33,0, 0,0,0,1,0,0));
        // fill A..D
        vq.push_back(mk(1,1,0,64'hA0,0, 1,64'hA0,0,0,0,0));
        vq.push_back(mk(1,1,0,64'hB0,0, 2,64'hB0,64'hA0,0,0,0));
        vq.push_back(mk(1,1,0,64'hC0,0, 3,64'hC0,64'hB0,0,0,0));
        vq.push_back(mk(1,1,0,64'hD0,0, 4,64'hD0,64'hC0,0,1,0));
        // pop1/push1 at full is legal
        vq.push_back(mk(1,1,0,64'hE0,1, 4,64'hE0,64'hC0,0,1,0));
        // push at full overflows; later requests ignored
        vq.push_back(mk(1,1,0,64'hF0,0, 4,64'hE0,64'hC0,0,1,2));
        vq.push_back(mk(1,1,0,64'h77,1, 4,64'hE0,64'hC0,0,1,2));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0));
        // underflow from empty, sticky until reset
        vq.push_back(mk(1,0,0,0,1, 0,0,0,1,0,1));
        vq.push_back(mk(1,1,0,64'h5,0, 0,0,0,1,0,1));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0));
        vq.push_back(mk(1,1,0,64'h5,0, 1,64'h5,0,0,0,0));
        vq.push_back(mk(1,1,0,64'h6,0, 2,64'h6,64'h5,0,0,0));
        // illegal pop; first trap code is kept
        vq.push_back(mk(1,1,0,64'h9,3, 2,64'h6,64'h5,0,0,3));
        vq.push_back(mk(1,0,0,0,2, 2,64'h6,64'h5,0,0,3));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0));
        // pop 2 with one entry underflows
        vq.push_back(mk(1,1,0,64'h11,0, 1,64'h11,0,0,0,0));
        vq.push_back(mk(1,0,0,0,2, 1,64'h11,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,0,0));
        // pop2/push1 at full, w32 ignored without push
        vq.push_back(mk(1,1,0,64'h1,0, 1,64'h1,0,0,0,0));
        vq.push_back(mk(1,1,0,64'h2,0, 2,64'h2,64'h1,0,0,0));
        vq.push_back(mk(1,1,0,64'h3,0, 3,64'h3,64'h2,0,0,0));
        vq.push_back(mk(1,1,0,64'h4,0, 4,64'h4,64'h3,0,1,0));
        vq.push_back(mk(1,1,0,64'h9,2, 3,64'h9,64'h2,0,0,0));
        vq.push_back(mk(1,0,1,64'hDEAD,1, 2,64'h2,64'h1,0,0,0));
        vq.push_back(mk(1,1,0,64'hFFFF_FFFF_FFFF_FFFF,0,
                        3,64'hFFFF_FFFF_FFFF_FFFF,64'h2,0,0,0));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].push, vq[i].w32,
                  vq[i].data, vq[i].pop);
            chk("count", i, W'(bus.count), W'(vq[i].cnt));
            chk("result", i, bus.result, vq[i].res);
            chk("next", i, bus.next, vq[i].nxt);
            chk("empty", i, W'(bus.result_empty), W'(vq[i].emp));
            chk("full", i, W'(bus.full), W'(vq[i].ful));
            chk("trap", i, W'(bus.trap), W'(vq[i].trp));
        end

        // rotate a full stack: pop1/push1 repeatedly keeps count at D
        drive(1'b0, 1'b0, 1'b0, '0, 2'd0);
        for (int k = 0; k < D; k++)
            drive(1'b1, 1'b1, 1'b0, W'(64'h100 + k), 2'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, W'(64'h200 + k), 2'd1);
            chk("rot_count", 100 + k, W'(bus.count), W'(D));
            chk("rot_result", 100 + k, bus.result, W'(64'h200 + k));
            chk("rot_next", 100 + k, bus.next, W'(64'h102));
        end
        drive(1'b1, 1'b0, 1'b0, '0, 2'd2);
        chk("rot_pop2", 110, bus.result, W'(64'h101));
        chk("rot_pop2_cnt", 110, W'(bus.count), W'(2));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
